// File: rtl/spi_mem.sv
// spi_mem: 256 x 8 byte memory behind the SPI slave shift interface.
// Consumes 10-bit command words {opcode[1:0], payload[7:0]} from the SPI
// receiver and returns read data to the SPI transmitter with a one-cycle
// tx_valid strobe. Write and read address registers are fully independent.
// The storage array is not reset, so preloaded or written contents survive
// a reset.
module spi_mem #(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [ADDR_SIZE+1:0] din,
   input  logic                 rx_valid,
   output logic [7:0]           dout,
   output logic                 tx_valid
);

   // Command opcodes carried in din[ADDR_SIZE+1:ADDR_SIZE]
   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_DATA = 2'b11;

   // Byte storage; name kept stable so benches can preload it hierarchically
   logic [7:0] mem [0:MEM_DEPTH-1];

   // Address registers
   logic [ADDR_SIZE-1:0] wr_addr;
   logic [ADDR_SIZE-1:0] rd_addr;

   // Split command word
   logic [1:0]           opcode_s;
   logic [ADDR_SIZE-1:0] payload_s;

   // One-hot command strobes, qualified by rx_valid
   logic ld_wr_addr_s;
   logic wr_data_s;
   logic ld_rd_addr_s;
   logic rd_data_s;

   assign opcode_s  = din[ADDR_SIZE+1:ADDR_SIZE];
   assign payload_s = din[ADDR_SIZE-1:0];

   // Decode the incoming command into individual strobes; nothing fires without rx_valid
   always_comb begin
      ld_wr_addr_s = 1'b0;
      wr_data_s    = 1'b0;
      ld_rd_addr_s = 1'b0;
      rd_data_s    = 1'b0;
      if (rx_valid) begin
         case (opcode_s)
            OP_WR_ADDR: ld_wr_addr_s = 1'b1;
            OP_WR_DATA: wr_data_s    = 1'b1;
            OP_RD_ADDR: ld_rd_addr_s = 1'b1;
            OP_RD_DATA: rd_data_s    = 1'b1;
            default: begin
               ld_wr_addr_s = 1'b0;
               wr_data_s    = 1'b0;
               ld_rd_addr_s = 1'b0;
               rd_data_s    = 1'b0;
            end
         endcase
      end else begin
         ld_wr_addr_s = 1'b0;
         wr_data_s    = 1'b0;
         ld_rd_addr_s = 1'b0;
         rd_data_s    = 1'b0;
      end
   end

   // Write-address register: loaded only by a write-address command, never by reads
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_addr <= {ADDR_SIZE{1'b0}};
      end else if (ld_wr_addr_s) begin
         wr_addr <= payload_s;
      end
   end

   // Read-address register: loaded only by a read-address command, never by writes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_addr <= {ADDR_SIZE{1'b0}};
      end else if (ld_rd_addr_s) begin
         rd_addr <= payload_s;
      end
   end

   // Storage write port; deliberately outside the reset so contents persist
   always_ff @(posedge clk) begin
      if (wr_data_s) begin
         mem[wr_addr] <= payload_s[7:0];
      end
   end

   // Read data register: captures mem[rd_addr] on a read-data command, otherwise holds
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout <= 8'h00;
      end else if (rd_data_s) begin
         dout <= mem[rd_addr];
      end
   end

   // Transmit strobe: high for exactly the cycle after each accepted read-data command
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_valid <= 1'b0;
      end else begin
         tx_valid <= rd_data_s;
      end
   end

endmodule

// File: tb/tb_spi_mem.sv
// Scoreboard bench for spi_mem: the driver pushes the expected byte and the
// cycle it should appear in for every read-data command; a separate monitor
// pops and compares whenever tx_valid is seen.
module tb_spi_mem;

   logic       clk;
   logic       rst_n;
   logic [9:0] din;
   logic       rx_valid;
   logic [7:0] dout;
   logic       tx_valid;

   typedef struct {
      int         due;
      logic [7:0] data;
   } exp_t;

   exp_t sb_q[$];
   int   cyc;
   int   errors;
   int   checks;

   spi_mem #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .din      (din),
      .rx_valid (rx_valid),
      .dout     (dout),
      .tx_valid (tx_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter used to time-stamp expected responses
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got 0x%02h expected 0x%02h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Drive one command word one cycle ahead of the capturing edge
   task automatic send(input logic v, input logic [1:0] op, input logic [7:0] pl,
                       input logic [7:0] exp);
      exp_t e;
      @(posedge clk);
      #1;
      rx_valid = v;
      din      = {op, pl};
      if (v && op == 2'b11) begin
         e.due  = cyc + 1;
         e.data = exp;
         sb_q.push_back(e);
      end
   endtask

   // Monitor: every tx_valid must match the oldest outstanding expectation in time and data
   always @(negedge clk) begin
      if (rst_n) begin
         while (sb_q.size() > 0 && sb_q[0].due < cyc) begin
            errors = errors + 1;
            checks = checks + 1;
            $display("FAIL missed_read: no tx_valid for expected 0x%02h due cycle %0d", sb_q[0].data, sb_q[0].due);
            void'(sb_q.pop_front());
         end
         if (tx_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
               errors = errors + 1;
               checks = checks + 1;
               $display("FAIL unexpected_tx: tx_valid=1 dout=0x%02h with nothing expected (cycle %0d)", dout, cyc);
            end else begin
               checks = checks + 1;
               if (sb_q[0].due != cyc || dout !== sb_q[0].data) begin
                  errors = errors + 1;
                  $display("FAIL read_data: got 0x%02h at cycle %0d expected 0x%02h at cycle %0d",
                           dout, cyc, sb_q[0].data, sb_q[0].due);
               end
               void'(sb_q.pop_front());
            end
         end
      end
   end

   initial begin
      errors   = 0;
      checks   = 0;
      cyc      = 0;
      rst_n    = 1'b0;
      rx_valid = 1'b0;
      din      = 10'd0;

      // Reset held for 5 cycles with rx_valid low
      repeat (5) @(posedge clk);
      #1;
      check8("reset_dout", dout, 8'h00);
      check8("reset_tx_valid", {7'd0, tx_valid}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      // Seed locations used later: mem[0x00]=0x3C, mem[0x20]=0x5A
      send(1'b1, 2'b00, 8'h00, 8'h00);
      send(1'b1, 2'b01, 8'h3C, 8'h00);
      send(1'b1, 2'b00, 8'h20, 8'h00);
      send(1'b1, 2'b01, 8'h5A, 8'h00);

      // Writes: mem[0xAA]=0x99, mem[0xAB]=0x9A
      send(1'b1, 2'b00, 8'hAA, 8'h00);
      send(1'b1, 2'b01, 8'h99, 8'h00);
      send(1'b1, 2'b00, 8'hAB, 8'h00);
      send(1'b1, 2'b01, 8'h9A, 8'h00);
      send(1'b0, 2'b00, 8'h00, 8'h00);
      #1;
      check8("tx_quiet_after_writes", {7'd0, tx_valid}, 8'h00);

      // Read back both locations, address then data with no gap
      send(1'b1, 2'b10, 8'hAA, 8'h00);
      send(1'b1, 2'b11, 8'h00, 8'h99);
      send(1'b1, 2'b10, 8'hAB, 8'h00);
      send(1'b1, 2'b11, 8'h5F, 8'h9A);
      send(1'b0, 2'b00, 8'h00, 8'h00);
      send(1'b0, 2'b00, 8'h00, 8'h00);

      // rx_valid gating: ignored read-data and write-data
      send(1'b0, 2'b11, 8'hF0, 8'h00);
      send(1'b0, 2'b01, 8'h00, 8'h00);
      send(1'b0, 2'b00, 8'h00, 8'h00);
      #1;
      check8("gated_dout_hold", dout, 8'h9A);
      check8("gated_tx_valid", {7'd0, tx_valid}, 8'h00);
      send(1'b1, 2'b11, 8'h00, 8'h9A);   // mem[0xAB] unchanged, rd_addr still 0xAB

      // Address independence plus back-to-back reads
      send(1'b1, 2'b00, 8'h10, 8'h00);
      send(1'b1, 2'b10, 8'h20, 8'h00);
      send(1'b1, 2'b01, 8'hFF, 8'h00);
      send(1'b1, 2'b11, 8'h00, 8'h5A);
      send(1'b1, 2'b11, 8'h00, 8'h5A);
      send(1'b1, 2'b10, 8'h10, 8'h00);
      send(1'b1, 2'b11, 8'h00, 8'hFF);

      // Write then read same location in consecutive cycles
      send(1'b1, 2'b00, 8'h77, 8'h00);
      send(1'b1, 2'b01, 8'hC3, 8'h00);
      send(1'b1, 2'b10, 8'h77, 8'h00);
      send(1'b1, 2'b11, 8'h00, 8'hC3);

      // Reset mid-operation: rd_addr=0xAA loaded, output non-zero before reset
      send(1'b1, 2'b10, 8'hAA, 8'h00);
      send(1'b1, 2'b11, 8'h00, 8'h99);
      send(1'b0, 2'b00, 8'h00, 8'h00);
      send(1'b0, 2'b00, 8'h00, 8'h00);
      #1;
      check8("pre_reset_dout", dout, 8'h99);
      rst_n = 1'b0;
      #1;
      check8("async_reset_dout", dout, 8'h00);
      check8("async_reset_tx_valid", {7'd0, tx_valid}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      send(1'b1, 2'b11, 8'h00, 8'h3C);   // rd_addr cleared to 0x00
      send(1'b1, 2'b10, 8'hAA, 8'h00);
      send(1'b1, 2'b11, 8'h00, 8'h99);   // mem survived reset
      send(1'b1, 2'b01, 8'h44, 8'h00);   // wr_addr cleared to 0x00
      send(1'b1, 2'b10, 8'h00, 8'h00);
      send(1'b1, 2'b11, 8'h00, 8'h44);
      send(1'b0, 2'b00, 8'h00, 8'h00);

      repeat (4) @(posedge clk);
      @(negedge clk);
      #1;
      checks = checks + 1;
      if (sb_q.size() != 0) begin
         errors = errors + 1;
         $display("FAIL drain: %0d reads outstanding, expected 0", sb_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
